// File: rtl/aes_dec_keysched_if.sv
// Round-key delivery bus for the AES-128 decrypt-side key scheduler: key load
// request from the host and valid/ready round-key stream to AddRoundKey.
interface aes_dec_keysched_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;

    modport master (
        output key_in, key_load, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, rk_last
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output busy, rk_valid, rk_out, rk_round, rk_last
    );
endinterface

// File: rtl/aes_dec_keysched.sv
// AES-128 key expansion that buffers all 11 round keys and serves them in reverse
// order (round 10 down to 0). Optional macro AES_KS_REPLAY_EN adds a replay input.
module aes_dec_keysched (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AES_KS_REPLAY_EN
    input  logic              replay,
`endif
    aes_dec_keysched_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_SERVE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic         valid_q, valid_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   round_q, round_d;
    logic         last_q, last_d;
    logic         busy_q, busy_d;
`ifdef AES_KS_REPLAY_EN
    logic         done_q, done_d;
`endif

    logic [3:0]   prev_idx_s;
    logic [127:0] prev_s;
    logic [31:0]  rot_s, sub_s, temp_s;
    logic [127:0] next_s;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One FIPS-197 expansion step from the previously stored round key
    always_comb begin
        prev_idx_s = cnt_q - 4'd1;
        if (cnt_q != 4'd0 && cnt_q <= 4'd11) begin
            prev_s = rk_q[prev_idx_s];
        end else begin
            prev_s = 128'd0;
        end
        rot_s  = {prev_s[23:0], prev_s[31:24]};
        temp_s = sub_s ^ {rcon(cnt_q), 24'h000000};
        next_s[127:96] = prev_s[127:96] ^ temp_s;
        next_s[95:64]  = prev_s[95:64]  ^ next_s[127:96];
        next_s[63:32]  = prev_s[63:32]  ^ next_s[95:64];
        next_s[31:0]   = prev_s[31:0]   ^ next_s[63:32];
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.din(rot_s[8*g +: 8]), .dout(sub_s[8*g +: 8]));
    end

    // Next-state and registered-output computation for IDLE/EXPAND/SERVE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rk_d    = rk_q;
        valid_d = valid_q;
        out_d   = out_q;
        round_d = round_q;
        last_d  = last_q;
`ifdef AES_KS_REPLAY_EN
        done_d  = done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.key_load) begin
                    rk_d[0] = bus.key_in;
                    cnt_d   = 4'd1;
                    state_d = ST_EXPAND;
                end
`ifdef AES_KS_REPLAY_EN
                else if (replay && done_q) begin
                    state_d = ST_SERVE;
                    idx_d   = 4'd10;
                    valid_d = 1'b1;
                    out_d   = rk_q[10];
                    round_d = 4'd10;
                    last_d  = 1'b0;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (cnt_q <= 4'd10) begin
                    rk_d[cnt_q] = next_s;
                    cnt_d       = cnt_q + 4'd1;
                end else begin
                    // rk[10] was written last cycle; start presenting it now
                    state_d = ST_SERVE;
                    cnt_d   = 4'd0;
                    idx_d   = 4'd10;
                    valid_d = 1'b1;
                    out_d   = rk_q[10];
                    round_d = 4'd10;
                    last_d  = 1'b0;
`ifdef AES_KS_REPLAY_EN
                    done_d  = 1'b1;
`endif
                end
            end
            ST_SERVE: begin
                if (valid_q && bus.rk_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        out_d   = 128'd0;
                        round_d = 4'd0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q - 4'd1;
                        out_d   = rk_q[idx_q - 4'd1];
                        round_d = idx_q - 4'd1;
                        last_d  = (idx_q == 4'd1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                idx_d   = 4'd0;
                valid_d = 1'b0;
                out_d   = 128'd0;
                round_d = 4'd0;
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, key buffer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            for (int i = 0; i < 11; i++) rk_q[i] <= 128'd0;
            valid_q <= 1'b0;
            out_q   <= 128'd0;
            round_q <= 4'd0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AES_KS_REPLAY_EN
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rk_q    <= rk_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            round_q <= round_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef AES_KS_REPLAY_EN
            done_q  <= done_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rk_valid = valid_q;
    assign bus.rk_out   = out_q;
    assign bus.rk_round = round_q;
    assign bus.rk_last  = last_q;
endmodule

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign dout = affine(gf_inv(din));
endmodule
